// File: rtl/alu_chk_pkg.sv
// Shared opcode encodings, FSM state type and counter width for the ALU result checker.
// No logic of its own; no timing and no backpressure.
// The stage-1 vector record lives here so the checker and any future consumers agree on layout.
package alu_chk_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] got;
    logic       carry;
  } vec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Golden 8-bit ALU reference: result, carry and a skip flag for undefined divide-by-zero.
// Purely combinational, zero latency.
// No flow control; the caller decides when the outputs are meaningful.
module alu_golden_model
  import alu_chk_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] sel,
  output logic [7:0] exp_out,
  output logic       exp_carry,
  output logic       skip
);

  logic [8:0]  sum9;
  logic [15:0] prod;

  // Carry is always the add carry, whatever the opcode.
  assign sum9      = {1'b0, a} + {1'b0, b};
  assign prod      = {8'd0, a} * {8'd0, b};
  assign exp_carry = sum9[8];

  always_comb begin
    exp_out = 8'h00;
    skip    = 1'b0;
    case (sel)
      OP_ADD:  exp_out = sum9[7:0];
      OP_SUB:  exp_out = a - b;
      OP_MUL:  exp_out = prod[7:0];
      OP_DIV: begin
        if (b == 8'h00) skip = 1'b1;
        else            exp_out = a / b;
      end
      OP_SHL:  exp_out = {a[6:0], 1'b0};
      OP_SHR:  exp_out = {1'b0, a[7:1]};
      OP_ROL:  exp_out = {a[6:0], a[7]};
      OP_ROR:  exp_out = {a[0], a[7:1]};
      OP_AND:  exp_out = a & b;
      OP_OR:   exp_out = a | b;
      OP_XOR:  exp_out = a ^ b;
      OP_NOR:  exp_out = ~(a | b);
      OP_NAND: exp_out = ~(a & b);
      OP_XNOR: exp_out = ~(a ^ b);
      OP_GT:   exp_out = (a > b) ? 8'h01 : 8'h00;
      OP_EQ:   exp_out = (a == b) ? 8'h01 : 8'h00;
      default: exp_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking ALU companion: compares ALU results to a golden model, counts pass/fail/skip, keeps first fail.
// Latency: counters update 2 cycles after in_valid; one vector per cycle. No backpressure: in_valid is never stalled.
// ALU_CHK_CARRY_EN: when defined, carry_out mismatches also count as fails.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int NUM_VECTORS  = 16,
  parameter bit HALT_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             ff_valid,
  output logic [3:0]       ff_sel,
  output logic [7:0]       ff_a,
  output logic [7:0]       ff_b,
  output logic [7:0]       ff_got,
  output logic [7:0]       ff_exp
);

  localparam logic [CNT_W-1:0] NUM_V = CNT_W'(NUM_VECTORS);

  chk_state_t       state_q, state_d;
  vec_t             s1_q;
  logic             s1_vld;
  logic [CNT_W-1:0] acc_cnt;

  logic [7:0] g_out;
  logic       g_carry, g_skip;
  logic       accept, rearm, mism, cmp_now, pass_now, fail_now, skip_now, halt_now;

  alu_golden_model u_golden (
    .a         (s1_q.a),
    .b         (s1_q.b),
    .sel       (s1_q.sel),
    .exp_out   (g_out),
    .exp_carry (g_carry),
    .skip      (g_skip)
  );

`ifdef ALU_CHK_CARRY_EN
  assign mism = (g_out != s1_q.got) || (g_carry != s1_q.carry);
`else
  logic unused_carry;
  assign unused_carry = g_carry ^ s1_q.carry;
  assign mism = (g_out != s1_q.got);
`endif

  // Stop accepting once the run quota is reached so DONE sees an exact count.
  assign accept   = (state_q == RUN) && in_valid && (acc_cnt < NUM_V);
  assign rearm    = start && ((state_q == IDLE) || (state_q == DONE));
  assign skip_now = s1_vld && g_skip;
  assign cmp_now  = s1_vld && !g_skip;
  assign pass_now = cmp_now && !mism;
  assign fail_now = cmp_now && mism;
  assign halt_now = fail_now && HALT_ON_FAIL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (halt_now)                          state_d = HALT;
          else if ((acc_cnt == NUM_V) && !s1_vld) state_d = DONE;
        end
        DONE: if (start) state_d = RUN;
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_vld   <= 1'b0;
      acc_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      ff_valid <= 1'b0;
      ff_sel   <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else if (clear || rearm) begin
      s1_vld   <= 1'b0;
      acc_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      ff_valid <= 1'b0;
      ff_sel   <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else begin
      // A vector captured on the halting edge is dropped, never compared.
      s1_vld <= accept && !halt_now;
      if (accept) begin
        s1_q    <= '{sel: alu_sel, a: a, b: b, got: alu_out, carry: carry_out};
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pass_now) pass_cnt <= sat_inc(pass_cnt);
      if (fail_now) fail_cnt <= sat_inc(fail_cnt);
      if (skip_now) skip_cnt <= sat_inc(skip_cnt);
      if (fail_now && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_sel   <= s1_q.sel;
        ff_a     <= s1_q.a;
        ff_b     <= s1_q.b;
        ff_got   <= s1_q.got;
        ff_exp   <= g_out;
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: opcode sweep, carry handling, skip, halt capture, reset and clear.
// Expected values are hand-computed constants; ALU_CHK_CARRY_EN selects the carry-fail expectation.
module tb_alu_result_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        carry_out;
  logic        busy;
  logic        done;
  logic        halted;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] skip_cnt;
  logic        ff_valid;
  logic [3:0]  ff_sel;
  logic [7:0]  ff_a;
  logic [7:0]  ff_b;
  logic [7:0]  ff_got;
  logic [7:0]  ff_exp;

  int tests_run = 0;
  int tests_failed = 0;

  alu_result_checker #(.NUM_VECTORS(16), .HALT_ON_FAIL(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .halted    (halted),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .skip_cnt  (skip_cnt),
    .ff_valid  (ff_valid),
    .ff_sel    (ff_sel),
    .ff_a      (ff_a),
    .ff_b      (ff_b),
    .ff_got    (ff_got),
    .ff_exp    (ff_exp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden results for a=0x0A, b=0x02, opcodes 0..F.
  logic [7:0] sweep_exp [16] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                 8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] vo, input logic vc);
    in_valid  = 1'b1;
    alu_sel   = s;
    a         = va;
    b         = vb;
    alu_out   = vo;
    carry_out = vc;
    tick();
    in_valid  = 1'b0;
  endtask

  // Fresh run with a single vector; returns once its counts are visible.
  task automatic run_one(input logic [3:0] s, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vo, input logic vc);
    pulse_clear();
    pulse_start();
    drive(s, va, vb, vo, vc);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; alu_sel = '0; alu_out = '0; carry_out = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_pass", pass_cnt, 16'd0);
    check("rst_fail", fail_cnt, 16'd0);
    check("rst_skip", skip_cnt, 16'd0);
    check("rst_ffv", 16'(ff_valid), 16'd0);

    // Full good sweep, back to back.
    pulse_start();
    check("sweep_busy", 16'(busy), 16'd1);
    for (int i = 0; i < 16; i++) drive(4'(i), 8'h0A, 8'h02, sweep_exp[i], 1'b0);
    tick();
    check("sweep_pass", pass_cnt, 16'd16);
    check("sweep_fail", fail_cnt, 16'd0);
    check("sweep_skip", skip_cnt, 16'd0);
    tick();
    check("sweep_done", 16'(done), 16'd1);
    check("sweep_busy_end", 16'(busy), 16'd0);

    // Restart from DONE wipes counters.
    pulse_start();
    check("rearm_pass", pass_cnt, 16'd0);
    check("rearm_busy", 16'(busy), 16'd1);

    // Wrong results expose the golden value through the capture.
    run_one(4'h0, 8'h0A, 8'h02, 8'h00, 1'b0);
    check("add_exp", 16'(ff_exp), 16'h000C);
    run_one(4'h3, 8'h0A, 8'h02, 8'h00, 1'b0);
    check("div_exp", 16'(ff_exp), 16'h0005);

    // Carry handling: 0xF6 + 0x0A wraps to 0x00 with carry.
    run_one(4'h0, 8'hF6, 8'h0A, 8'h00, 1'b1);
    check("carry_ok_pass", pass_cnt, 16'd1);
    check("carry_ok_fail", fail_cnt, 16'd0);
    run_one(4'h0, 8'hF6, 8'h0A, 8'h00, 1'b0);
`ifdef ALU_CHK_CARRY_EN
    check("carry_bad_fail", fail_cnt, 16'd1);
`else
    check("carry_bad_fail", fail_cnt, 16'd0);
`endif

    // Divide by zero is skipped.
    run_one(4'h3, 8'h0A, 8'h00, 8'h00, 1'b0);
    check("skip_skip", skip_cnt, 16'd1);
    check("skip_pass", pass_cnt, 16'd0);
    check("skip_fail", fail_cnt, 16'd0);

    // Halt on the third vector; the vector behind it must not count.
    pulse_clear();
    pulse_start();
    drive(4'h0, 8'h0A, 8'h02, 8'h0C, 1'b0);
    drive(4'h1, 8'h0A, 8'h02, 8'h08, 1'b0);
    drive(4'h2, 8'h0A, 8'h02, 8'hAA, 1'b0);
    drive(4'h3, 8'h0A, 8'h02, 8'h05, 1'b0);
    drive(4'h4, 8'h0A, 8'h02, 8'h14, 1'b0);
    tick(); tick();
    check("halt_halted", 16'(halted), 16'd1);
    check("halt_fail", fail_cnt, 16'd1);
    check("halt_pass", pass_cnt, 16'd2);
    check("halt_ffv", 16'(ff_valid), 16'd1);
    check("halt_ffsel", 16'(ff_sel), 16'd2);
    check("halt_ffa", 16'(ff_a), 16'h000A);
    check("halt_ffb", 16'(ff_b), 16'h0002);
    check("halt_ffgot", 16'(ff_got), 16'h00AA);
    check("halt_ffexp", 16'(ff_exp), 16'h0014);
    pulse_start();
    check("halt_sticky", 16'(halted), 16'd1);

    // Asynchronous reset mid-run.
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 5; i++) drive(4'(i), 8'h0A, 8'h02, sweep_exp[i], 1'b0);
    tick();
    check("mid_pass", pass_cnt, 16'd5);
    rst_n = 1'b0;
    #2;
    check("arst_pass", pass_cnt, 16'd0);
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_done", 16'(done), 16'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // clear beats a simultaneous start.
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("sc_busy", 16'(busy), 16'd0);
    check("sc_done", 16'(done), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
